// File: rtl/switch_instr_decoder.sv
// Switch/button instruction entry front-end: debounces the button, captures a
// 16-bit word high byte first, and decodes it into the datapath control bundle.
module switch_instr_decoder #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  sw,
  input  logic        btn_n,
  output logic [15:0] regEn,
  output logic [3:0]  muxA,
  output logic [3:0]  muxB,
  output logic        muxBimm,
  output logic [7:0]  Opcode,
  output logic [15:0] imm16,
  output logic [1:0]  phase,
  output logic [7:0]  exec_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    CAP_HI = 2'b00,
    CAP_LO = 2'b01,
    EXEC   = 2'b10
  } state_t;

  state_t            r_state, w_next;
  logic              r_sync1, r_sync2, r_db;
  logic [CNT_W-1:0]  r_cnt;
  logic [15:0]       r_instr;
  logic [7:0]        r_exec_cnt;
  logic              w_differ, w_flip, w_press;
  logic [3:0]        w_op, w_rd, w_ext, w_rs;
  logic              w_nop;

  // Button conditioning: 2-FF synchronizer then a stability counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_db    <= 1'b1;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= btn_n;
      r_sync2 <= r_sync1;
      if (!w_differ) begin
        r_cnt <= '0;
      end else if (w_flip) begin
        r_db  <= r_sync2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign w_differ = (r_sync2 != r_db);
  assign w_flip   = w_differ && (r_cnt == CNT_MAX);
  // Pulse in the cycle the debounced level falls; releases never pulse.
  assign w_press  = w_flip && r_db;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= CAP_HI;
      r_instr    <= 16'h0000;
      r_exec_cnt <= 8'h00;
    end else begin
      r_state <= w_next;
      if (r_state == CAP_HI && w_press) r_instr[15:8] <= sw;
      if (r_state == CAP_LO && w_press) r_instr[7:0]  <= sw;
      if (r_state == EXEC && !w_nop)    r_exec_cnt    <= r_exec_cnt + 8'd1;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      CAP_HI:  if (w_press) w_next = CAP_LO;
      CAP_LO:  if (w_press) w_next = EXEC;
      EXEC:    w_next = CAP_HI;
      default: w_next = CAP_HI;
    endcase
  end

  assign w_op  = r_instr[15:12];
  assign w_rd  = r_instr[11:8];
  assign w_ext = r_instr[7:4];
  assign w_rs  = r_instr[3:0];
  assign w_nop = (w_op == 4'hF);

  // Reserved op 0xF presents a neutral register-form bundle; it never writes.
  always_comb begin
    Opcode  = 8'h00;
    muxBimm = 1'b0;
    muxB    = 4'h0;
    if (w_op == 4'h0) begin
      Opcode = {w_op, w_ext};
      muxB   = w_rs;
    end else if (!w_nop) begin
      Opcode  = {w_op, 4'h0};
      muxBimm = 1'b1;
    end
  end

  assign muxA       = w_rd;
  assign imm16      = {{8{r_instr[7]}}, r_instr[7:0]};
  assign regEn      = (r_state == EXEC && !w_nop) ? (16'h0001 << w_rd) : 16'h0000;
  assign phase      = r_state;
  assign exec_count = r_exec_cnt;

endmodule

// File: tb/tb_switch_instr_decoder.sv
// Bench for switch_instr_decoder: directed vector table, bounce/reset/hold
// sequences, and random instructions checked against a field-level model.
module tb_switch_instr_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  sw;
  logic        btn_n;
  logic [15:0] regEn;
  logic [3:0]  muxA, muxB;
  logic        muxBimm;
  logic [7:0]  Opcode;
  logic [15:0] imm16;
  logic [1:0]  phase;
  logic [7:0]  exec_count;

  switch_instr_decoder #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .sw(sw), .btn_n(btn_n), .regEn(regEn),
    .muxA(muxA), .muxB(muxB), .muxBimm(muxBimm), .Opcode(Opcode),
    .imm16(imm16), .phase(phase), .exec_count(exec_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  hi, lo;
    logic [15:0] regEn;
    logic [3:0]  muxA, muxB;
    logic        bimm;
    logic [7:0]  op;
    logic [15:0] imm;
    bit          nop;
  } vec_t;

  int          n_pass = 0, n_total = 0;
  int          n_exec, n_regen;
  logic [15:0] s_regEn, s_imm;
  logic [3:0]  s_muxA, s_muxB;
  logic        s_bimm;
  logic [7:0]  s_op;
  logic [7:0]  m_count = 8'h00;
  vec_t        last;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(negedge clk);
    if (phase == 2'b10) begin
      n_exec++;
      s_regEn = regEn; s_imm = imm16; s_muxA = muxA; s_muxB = muxB;
      s_bimm = muxBimm; s_op = Opcode;
    end
    if (regEn != 16'h0000) n_regen++;
  endtask

  task automatic press(input logic [7:0] val);
    sw = val; btn_n = 1'b0;
    repeat (10) tick();
    sw = 8'($urandom); btn_n = 1'b1;
    repeat (10) tick();
  endtask

  // Reference decode from the instruction-format rules.
  function automatic vec_t model(input logic [15:0] w);
    vec_t v;
    int op, rd, ext, rs, lo;
    op = int'(w) / 4096; rd = (int'(w) / 256) % 16;
    ext = (int'(w) / 16) % 16; rs = int'(w) % 16; lo = int'(w) % 256;
    v.hi   = w[15:8];
    v.lo   = w[7:0];
    v.nop  = (op == 15);
    v.muxA = 4'(rd);
    v.imm  = 16'((lo >= 128) ? lo + 65280 : lo);
    v.regEn = v.nop ? 16'h0 : 16'(1 << rd);
    v.op   = 8'(op * 16 + ((op == 0) ? ext : 0));
    v.bimm = (op != 0);
    v.muxB = (op == 0) ? 4'(rs) : 4'h0;
    return v;
  endfunction

  task automatic run_vec(input vec_t v);
    n_exec = 0; n_regen = 0;
    press(v.hi);
    check("phase_after_hi", 32'(phase), 32'h1);
    press(v.lo);
    if (!v.nop) m_count = m_count + 8'd1;
    check("exec_cycles", n_exec, 1);
    check("regen_cycles", n_regen, (v.regEn != 0) ? 1 : 0);
    check("phase_after_lo", 32'(phase), 32'h0);
    check("regEn", 32'(s_regEn), 32'(v.regEn));
    check("muxA", 32'(s_muxA), 32'(v.muxA));
    check("imm16", 32'(s_imm), 32'(v.imm));
    if (!v.nop) begin
      check("Opcode", 32'(s_op), 32'(v.op));
      check("muxBimm", 32'(s_bimm), 32'(v.bimm));
      check("muxB", 32'(s_muxB), 32'(v.muxB));
    end
    check("exec_count", 32'(exec_count), 32'(m_count));
    last = v;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    m_count = 8'h00;
    tick();
  endtask

  vec_t tbl[5];

  initial begin
    tbl[0] = '{hi:8'h03, lo:8'h55, regEn:16'h0008, muxA:4'h3, muxB:4'h5, bimm:1'b0, op:8'h05, imm:16'h0055, nop:1'b0};
    tbl[1] = '{hi:8'h5F, lo:8'hFF, regEn:16'h8000, muxA:4'hF, muxB:4'h0, bimm:1'b1, op:8'h50, imm:16'hFFFF, nop:1'b0};
    tbl[2] = '{hi:8'h52, lo:8'h7F, regEn:16'h0004, muxA:4'h2, muxB:4'h0, bimm:1'b1, op:8'h50, imm:16'h007F, nop:1'b0};
    tbl[3] = '{hi:8'hF1, lo:8'h23, regEn:16'h0000, muxA:4'h1, muxB:4'h0, bimm:1'b0, op:8'h00, imm:16'h0023, nop:1'b1};
    tbl[4] = '{hi:8'h0A, lo:8'h9C, regEn:16'h0400, muxA:4'hA, muxB:4'hC, bimm:1'b0, op:8'h09, imm:16'hFF9C, nop:1'b0};

    sw = 8'h00; btn_n = 1'b1; rst = 1'b0;
    repeat (3) tick();
    check("rst_regEn", 32'(regEn), 32'h0);
    check("rst_muxA", 32'(muxA), 32'h0);
    check("rst_muxB", 32'(muxB), 32'h0);
    check("rst_muxBimm", 32'(muxBimm), 32'h0);
    check("rst_Opcode", 32'(Opcode), 32'h0);
    check("rst_imm16", 32'(imm16), 32'h0);
    check("rst_phase", 32'(phase), 32'h0);
    check("rst_exec_count", 32'(exec_count), 32'h0);
    rst = 1'b1;
    tick();

    foreach (tbl[i]) run_vec(tbl[i]);

    // Bounce: 2-cycle toggles and a 3-cycle glitch never reach the threshold.
    n_exec = 0; n_regen = 0;
    for (int i = 0; i < 10; i++) begin
      btn_n = ~btn_n;
      repeat (2) tick();
    end
    btn_n = 1'b1;
    repeat (20) tick();
    check("bounce_phase", 32'(phase), 32'h0);
    check("bounce_imm16", 32'(imm16), 32'(last.imm));
    check("bounce_muxA", 32'(muxA), 32'(last.muxA));
    btn_n = 1'b0;
    repeat (3) tick();
    btn_n = 1'b1;
    repeat (20) tick();
    check("glitch_phase", 32'(phase), 32'h0);
    check("glitch_regen", n_regen, 0);

    // Reset after the high byte discards it.
    press(8'h03);
    check("pre_rst_phase", 32'(phase), 32'h1);
    do_reset();
    check("mid_rst_phase", 32'(phase), 32'h0);
    check("mid_rst_count", 32'(exec_count), 32'h0);
    check("mid_rst_imm16", 32'(imm16), 32'h0);
    run_vec(model(16'h5201));

    for (int i = 0; i < 40; i++) run_vec(model(16'($urandom)));

    // 256 executed instructions wrap the counter back to zero.
    do_reset();
    for (int i = 0; i < 256; i++) begin
      logic [15:0] w;
      w = 16'($urandom);
      if (w[15:12] == 4'hF) w[15:12] = 4'h1;
      run_vec(model(w));
    end
    check("wrap_count", 32'(exec_count), 32'h0);

    // A long hold produces a single press.
    n_exec = 0;
    sw = 8'h07; btn_n = 1'b0;
    repeat (100) tick();
    check("hold_phase", 32'(phase), 32'h1);
    btn_n = 1'b1;
    repeat (20) tick();
    check("hold_release_phase", 32'(phase), 32'h1);
    check("hold_exec", n_exec, 0);
    press(8'h11);
    check("hold_done_exec", n_exec, 1);
    check("hold_done_regEn", 32'(s_regEn), 32'h0080);
    check("hold_done_count", 32'(exec_count), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
